// File: rtl/cond_exec_stage_pkg.sv
// Shared constants for the EX-stage condition logic: condition codes,
// NZCV flag bit positions and the flag-write-enable bit positions.
package cond_exec_stage_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_exec_stage_cond_check.sv
// Purely combinational ARM-style condition evaluation of a 4-bit condition
// field against an NZCV flag vector; also usable by the decoder.
module cond_check
  import cond_exec_stage_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);

  logic n, z, c, v;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign c = flags_i[FLAG_C];
  assign v = flags_i[FLAG_V];

  always_comb begin
    cond_ex_o = 1'b1;
    unique case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = !z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = !c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = !n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = !v;
      COND_HI: cond_ex_o = c && !z;
      COND_LS: cond_ex_o = !c || z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = !z && (n == v);
      COND_LE: cond_ex_o = z || (n != v);
      // 0xF is reserved and executes unconditionally, same as AL.
      default: cond_ex_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// EX-stage conditional execution: owns the NZCV flag register, gates flag,
// register, memory and PC writes on the condition, and feeds the EX/MEM register.
module cond_exec_stage
  import cond_exec_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [3:0]        ex_cond,
  input  logic [1:0]        ex_flag_w,
  input  logic              ex_pcs,
  input  logic              ex_reg_w,
  input  logic              ex_mem_w,
  input  logic              ex_no_write,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic [RD_W-1:0]   ex_rd,
  input  logic [3:0]        alu_flags,
  input  logic              stall,
  input  logic              flush,
  output logic              cond_ex,
  output logic              pcsrc,
  output logic [3:0]        flags,
  output logic              mem_valid,
  output logic              mem_reg_w,
  output logic              mem_mem_w,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [RD_W-1:0]   mem_rd
);

  logic [3:0]        flags_q, flags_d;
  logic              valid_q, valid_d;
  logic              reg_w_q, reg_w_d;
  logic              mem_w_q, mem_w_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              go;
  logic              load_en;

  // Conditions are evaluated against the registered flags; a flag writer's
  // update lands at the end of its EX cycle, so the next instruction sees it.
  cond_check u_cond_check (
    .cond_i   (ex_cond),
    .flags_i  (flags_q),
    .cond_ex_o(cond_ex)
  );

  // Handshake: ex_valid qualifies the EX slot; stall holds every register
  // (EX/MEM and flags) and blocks PC redirect; flush kills the EX slot and
  // overrides stall by forcing a bubble into EX/MEM.
  assign go      = ex_valid && cond_ex && !flush;
  assign pcsrc   = go && ex_pcs && !stall;
  assign load_en = !stall || flush;

  always_comb begin
    flags_d = flags_q;
    if (go && !stall) begin
      if (ex_flag_w[FLAGW_NZ]) begin
        flags_d[FLAG_N] = alu_flags[FLAG_N];
        flags_d[FLAG_Z] = alu_flags[FLAG_Z];
      end
      if (ex_flag_w[FLAGW_CV]) begin
        flags_d[FLAG_C] = alu_flags[FLAG_C];
        flags_d[FLAG_V] = alu_flags[FLAG_V];
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    reg_w_d  = reg_w_q;
    mem_w_d  = mem_w_q;
    result_d = result_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    if (load_en) begin
      valid_d  = go;
      // PC-destination writes leave through pcsrc, never the register file.
      reg_w_d  = go && ex_reg_w && !ex_no_write && !ex_pcs;
      mem_w_d  = go && ex_mem_w;
      result_d = ex_alu_result;
      wdata_d  = ex_write_data;
      rd_d     = ex_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q  <= '0;
      valid_q  <= 1'b0;
      reg_w_q  <= 1'b0;
      mem_w_q  <= 1'b0;
      result_q <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
    end else begin
      flags_q  <= flags_d;
      valid_q  <= valid_d;
      reg_w_q  <= reg_w_d;
      mem_w_q  <= mem_w_d;
      result_q <= result_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
    end
  end

  assign flags          = flags_q;
  assign mem_valid      = valid_q;
  assign mem_reg_w      = reg_w_q;
  assign mem_mem_w      = mem_w_q;
  assign mem_alu_result = result_q;
  assign mem_write_data = wdata_q;
  assign mem_rd         = rd_q;

endmodule
